ipml_sync_fifo_fwft: RTL and testbench
======================================

Name: ipml_sync_fifo_fwft

Overview:
- Single-clock, parametrised FIFO. Successor to the dual-clock controller plus SDP-RAM FIFO wrapper.
- Adds a selectable first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags.
- Count, almost-full and almost-empty outputs are registered.
- Used by peripheral TX/RX paths that run on one bus clock.

Parameters:
- DATA_WIDTH, 32, data width in bits (1..1152).
- DEPTH_WIDTH, 10, log2 of total capacity (4..16). Capacity is 2^DEPTH_WIDTH words.
- FWFT_EN, 0, read mode. 0: standard (data appears one cycle after rd_en). 1: FWFT (head word presented while not empty).
- ALMOST_FULL_NUM, 2^DEPTH_WIDTH-4, almost_full threshold in words.
- ALMOST_EMPTY_NUM, 4, almost_empty threshold in words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush, active high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- wr_full  out  1  no free space.
- almost_full  out  1  count >= ALMOST_FULL_NUM.
- overflow  out  1  sticky: a write was rejected.
- rd_en  in  1  read request (pop).
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data carries a freshly popped word (standard mode); equals !rd_empty in FWFT mode.
- rd_empty  out  1  no readable word.
- almost_empty  out  1  count <= ALMOST_EMPTY_NUM.
- underflow  out  1  sticky: a read was rejected.
- water_level  out  DEPTH_WIDTH+1  words held, including the FWFT output stage.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (rst_n low, asynchronous):
  - pointers = 0, water_level = 0, rd_data = 0.
  - rd_empty = 1, almost_empty = 1, wr_full = 0, almost_full = 0.
  - overflow = 0, underflow = 0, rd_valid = 0.
  - Memory contents are not reset.
- Acceptance rules:
  - Write accepted iff wr_en && !wr_full, using the registered flag value in that cycle.
  - Read accepted iff rd_en && !rd_empty.
  - A full FIFO rejects a write even if a read is accepted in the same cycle. That sets overflow.
  - An empty FIFO rejects a read even if a write is accepted in the same cycle. That sets underflow.
- Pointers:
  - Binary write/read pointers of DEPTH_WIDTH+1 bits; the MSB is the wrap bit.
  - Memory index is the low DEPTH_WIDTH bits.
  - Wrap from 2^DEPTH_WIDTH-1 to 0 is seamless.
- water_level:
  - Next value = current + accepted_wr - accepted_rd, updated at the same edge as the pointers.
  - Range 0..2^DEPTH_WIDTH; never wraps.
- Flag updates:
  - wr_full = (water_level == 2^DEPTH_WIDTH).
  - almost_full and almost_empty are registered and computed from the next water_level value, so they change at the same edge as water_level.
- Standard mode (FWFT_EN=0):
  - Accepted read at edge k: rd_data = mem[rd_ptr] after edge k, and rd_valid = 1 for that one cycle.
  - rd_data holds its value otherwise.
  - rd_empty = (water_level == 0), updated at the same edge as the accepted write.
- FWFT mode (FWFT_EN=1):
  - An output-stage register holds the head word. rd_empty = !stage_valid.
  - First write into an empty FIFO at edge k: stage loads at edge k+1, so rd_empty deasserts after edge k+1. water_level is already 1 after edge k.
  - Accepted read at edge k: if a RAM word is available, the stage reloads at edge k, giving back-to-back pops at full rate. Otherwise stage_valid clears.
  - Total capacity, including the stage, remains 2^DEPTH_WIDTH.
- Simultaneous read and write on a non-full, non-empty FIFO: water_level is unchanged and both pointers advance.
- clr:
  - Same effect as reset on pointers, water_level, all flags and the stage, at the next edge.
  - Clears overflow and underflow.
  - Has priority over wr_en and rd_en in the same cycle.
- overflow and underflow stay set until clr or reset.
- A mid-operation reset returns everything to the reset values immediately. The first write after rst_n rises behaves as a write into an empty FIFO.

Test Plan:
- Fill/drain, DEPTH_WIDTH=4, FWFT_EN=0: write 16 words 0x00..0x0F.
  - After the 16th write: wr_full=1, water_level=16, almost_full=1.
  - 16 reads return 0x00..0x0F, each one cycle after rd_en with rd_valid pulsing.
  - End state: rd_empty=1, water_level=0.
- Overflow/underflow: on a full FIFO, wr_en and rd_en together.
  - Read accepted, write rejected: overflow=1, water_level=15.
  - On an empty FIFO, rd_en: underflow=1.
  - Both flags stay set until clr pulses; after clr they are 0 and water_level=0.
- FWFT latency, FWFT_EN=1: single write of 0xA5 at edge k.
  - water_level=1 after edge k.
  - rd_empty=0 and rd_data=0xA5 after edge k+1.
  - rd_en pops it: rd_empty=1 after that edge.
- FWFT streaming: 40 continuous writes with rd_en held high.
  - Data 0..39 emerges in order with no bubbles after the first word.
  - water_level never exceeds 2.
- Pointer wrap: 3 fill/drain cycles of 10 words each on a 16-deep FIFO.
  - Data integrity holds across the 15->0 index wrap.
  - almost_empty toggles at the 4/5-word boundary.
- Reset mid-stream: assert rst_n low with 7 words held.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After release, 0x11 written then read returns 0x11.

Source files
------------

// File: rtl/ipml_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// ipml_sync_fifo_fwft : single-clock FIFO, standard or first-word-fall-through
// Revision 1.0
// ============================================================================
module ipml_sync_fifo_fwft #(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH_WIDTH      = 10,
  parameter int FWFT_EN          = 0,
  parameter int ALMOST_FULL_NUM  = (1 << DEPTH_WIDTH) - 4,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic                   underflow,
  output logic [DEPTH_WIDTH:0]   water_level
);

  localparam int                 c_depth = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] c_cap = (DEPTH_WIDTH+1)'(c_depth);
  localparam logic [DEPTH_WIDTH:0] c_af  = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] c_ae  = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem [c_depth];

  logic [DEPTH_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   level_q, level_d;
  logic                   af_q, af_d;
  logic                   ae_q, ae_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_load;
  logic                   w_valid_nxt;
  logic [DATA_WIDTH-1:0]  w_mem_rd;

  assign w_full   = (level_q == c_cap);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;
  assign w_mem_rd = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];

  // w_load: fetch RAM head into the output register and advance rd_ptr.
  generate
    if (FWFT_EN != 0) begin : g_fwft
      logic w_ram_avail;
      // RAM words = all held words minus the one sitting in the stage.
      assign w_ram_avail = (level_q != {{DEPTH_WIDTH{1'b0}}, valid_q});
      assign w_empty     = !valid_q;
      assign w_load      = w_ram_avail && (!valid_q || w_rd_acc);
      assign w_valid_nxt = w_load || (valid_q && !w_rd_acc);
    end else begin : g_std
      assign w_empty     = (level_q == '0);
      assign w_load      = w_rd_acc;
      assign w_valid_nxt = w_rd_acc;
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    af_d     = af_q;
    ae_d     = ae_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    valid_d  = valid_q;
    data_d   = data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      af_d     = 1'b0;
      ae_d     = 1'b1;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      valid_d  = 1'b0;
      data_d   = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{DEPTH_WIDTH{1'b0}}, w_wr_acc};
      rd_ptr_d = rd_ptr_q + {{DEPTH_WIDTH{1'b0}}, w_load};
      level_d  = level_q + {{DEPTH_WIDTH{1'b0}}, w_wr_acc}
                         - {{DEPTH_WIDTH{1'b0}}, w_rd_acc};
      af_d     = (level_d >= c_af);
      ae_d     = (level_d <= c_ae);
      ovf_d    = ovf_q || (wr_en && w_full);
      udf_d    = udf_q || (rd_en && w_empty);
      valid_d  = w_valid_nxt;
      if (w_load) begin
        data_d = w_mem_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !clr) begin
      mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  assign wr_full      = w_full;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign rd_data      = data_q;
  assign rd_valid     = valid_q;
  assign rd_empty     = w_empty;
  assign almost_empty = ae_q;
  assign underflow    = udf_q;
  assign water_level  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_ipml_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// tb_ipml_sync_fifo_fwft : standard and FWFT instances against a queue model
// Revision 1.0
// ============================================================================
module tb_ipml_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;

  logic       ds_full, ds_af, ds_ovf, ds_rv, ds_empty, ds_ae, ds_udf;
  logic [7:0] ds_rd;
  logic [4:0] ds_lvl;
  logic       df_full, df_af, df_ovf, df_rv, df_empty, df_ae, df_udf;
  logic [7:0] df_rd;
  logic [4:0] df_lvl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ipml_sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT_EN(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(ds_full), .almost_full(ds_af), .overflow(ds_ovf), .rd_en(rd_en),
    .rd_data(ds_rd), .rd_valid(ds_rv), .rd_empty(ds_empty),
    .almost_empty(ds_ae), .underflow(ds_udf), .water_level(ds_lvl));

  ipml_sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT_EN(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(df_full), .almost_full(df_af), .overflow(df_ovf), .rd_en(rd_en),
    .rd_data(df_rd), .rd_valid(df_rv), .rd_empty(df_empty),
    .almost_empty(df_ae), .underflow(df_udf), .water_level(df_lvl));

  // Model: a queue of every word held; FWFT adds a "head visible" flag.
  logic [7:0] sq[$];
  logic [7:0] fq[$];
  bit         s_ovf, s_udf, s_rv;
  logic [7:0] s_rd;
  bit         f_ovf, f_udf, f_vis;

  function automatic void model_reset();
    sq.delete();
    fq.delete();
    s_ovf = 0; s_udf = 0; s_rv = 0; s_rd = 8'h00;
    f_ovf = 0; f_udf = 0; f_vis = 0;
  endfunction

  function automatic void model_edge();
    int ps;
    if (clr) begin
      model_reset();
      return;
    end
    ps = sq.size();
    s_ovf = s_ovf || (wr_en && ps == 16);
    s_udf = s_udf || (rd_en && ps == 0);
    s_rv  = rd_en && ps > 0;
    if (s_rv) s_rd = sq.pop_front();
    if (wr_en && ps < 16) sq.push_back(wr_data);

    ps = fq.size();
    f_ovf = f_ovf || (wr_en && ps == 16);
    f_udf = f_udf || (rd_en && !f_vis);
    if (rd_en && f_vis) begin
      void'(fq.pop_front());
      f_vis = (ps > 1);
    end else if (!f_vis) begin
      f_vis = (ps > 0);
    end
    if (wr_en && ps < 16) fq.push_back(wr_data);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("std.water_level", 32'(ds_lvl), sq.size());
    chk("std.wr_full", 32'(ds_full), 32'(sq.size() == 16));
    chk("std.almost_full", 32'(ds_af), 32'(sq.size() >= 12));
    chk("std.almost_empty", 32'(ds_ae), 32'(sq.size() <= 4));
    chk("std.rd_empty", 32'(ds_empty), 32'(sq.size() == 0));
    chk("std.overflow", 32'(ds_ovf), 32'(s_ovf));
    chk("std.underflow", 32'(ds_udf), 32'(s_udf));
    chk("std.rd_valid", 32'(ds_rv), 32'(s_rv));
    if (s_rv) chk("std.rd_data", 32'(ds_rd), 32'(s_rd));
    chk("fwft.water_level", 32'(df_lvl), fq.size());
    chk("fwft.wr_full", 32'(df_full), 32'(fq.size() == 16));
    chk("fwft.almost_full", 32'(df_af), 32'(fq.size() >= 12));
    chk("fwft.almost_empty", 32'(df_ae), 32'(fq.size() <= 4));
    chk("fwft.rd_empty", 32'(df_empty), 32'(!f_vis));
    chk("fwft.rd_valid", 32'(df_rv), 32'(f_vis));
    chk("fwft.overflow", 32'(df_ovf), 32'(f_ovf));
    chk("fwft.underflow", 32'(df_udf), 32'(f_udf));
    if (f_vis) chk("fwft.rd_data", 32'(df_rd), 32'(fq[0]));
  end

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drive(input bit w, input logic [7:0] d, input bit r);
    wr_en = w; wr_data = d; rd_en = r;
    step();
  endtask

  task automatic pulse_clr();
    wr_en = 0; rd_en = 0; clr = 1;
    step();
    clr = 0;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, ".s_lvl"}, 32'(ds_lvl), 0);
    chk({tag, ".s_empty"}, 32'(ds_empty), 1);
    chk({tag, ".s_ae"}, 32'(ds_ae), 1);
    chk({tag, ".s_full"}, 32'(ds_full), 0);
    chk({tag, ".s_rv"}, 32'(ds_rv), 0);
    chk({tag, ".s_rd"}, 32'(ds_rd), 0);
    chk({tag, ".f_lvl"}, 32'(df_lvl), 0);
    chk({tag, ".f_empty"}, 32'(df_empty), 1);
    chk({tag, ".f_af"}, 32'(df_af), 0);
    chk({tag, ".f_flags"}, 32'({df_ovf, df_udf, ds_ovf, ds_udf}), 0);
    chk({tag, ".f_rd"}, 32'(df_rd), 0);
  endtask

  initial begin
    int fmax;
    rst_n = 0; clr = 0; wr_en = 0; wr_data = 0; rd_en = 0;
    model_reset();
    repeat (2) step();
    reset_literals("reset");
    rst_n = 1;
    step();

    // Fill/drain
    for (int i = 0; i < 16; i++) drive(1, 8'(i), 0);
    chk("fill.s_full", 32'(ds_full), 1);
    chk("fill.s_lvl", 32'(ds_lvl), 16);
    chk("fill.s_af", 32'(ds_af), 1);
    chk("fill.f_lvl", 32'(df_lvl), 16);
    for (int i = 0; i < 16; i++) begin
      drive(0, 8'h00, 1);
      chk("drain.s_rv", 32'(ds_rv), 1);
      chk("drain.s_rd", 32'(ds_rd), i);
    end
    drive(0, 8'h00, 0);
    chk("drain.s_rv_low", 32'(ds_rv), 0);
    chk("drain.s_empty", 32'(ds_empty), 1);
    chk("drain.s_lvl", 32'(ds_lvl), 0);
    chk("drain.f_empty", 32'(df_empty), 1);

    // Overflow / underflow
    for (int i = 0; i < 16; i++) drive(1, 8'(8'h20 + i), 0);
    drive(1, 8'hEE, 1);
    chk("ovf.s_ovf", 32'(ds_ovf), 1);
    chk("ovf.s_lvl", 32'(ds_lvl), 15);
    chk("ovf.f_ovf", 32'(df_ovf), 1);
    chk("ovf.f_lvl", 32'(df_lvl), 15);
    for (int i = 0; i < 15; i++) drive(0, 8'h00, 1);
    chk("udf.s_udf_pre", 32'(ds_udf), 0);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    chk("udf.s_udf", 32'(ds_udf), 1);
    chk("udf.f_udf", 32'(df_udf), 1);
    chk("udf.s_ovf_sticky", 32'(ds_ovf), 1);
    pulse_clr();
    chk("clr.flags", 32'({ds_ovf, ds_udf, df_ovf, df_udf}), 0);
    chk("clr.s_lvl", 32'(ds_lvl), 0);

    // FWFT latency
    drive(1, 8'hA5, 0);
    chk("lat.f_lvl", 32'(df_lvl), 1);
    chk("lat.f_empty_k", 32'(df_empty), 1);
    drive(0, 8'h00, 0);
    chk("lat.f_empty_k1", 32'(df_empty), 0);
    chk("lat.f_rd", 32'(df_rd), 8'hA5);
    drive(0, 8'h00, 1);
    chk("lat.f_empty_pop", 32'(df_empty), 1);
    chk("lat.s_rd", 32'(ds_rd), 8'hA5);
    pulse_clr();

    // Streaming with rd_en held high
    fmax = 0;
    for (int n = 0; n < 44; n++) begin
      drive(n < 40, 8'(n), 1);
      if (32'(df_lvl) > fmax) fmax = 32'(df_lvl);
      if (n >= 1 && n <= 40) begin
        chk("stream.f_valid", 32'(df_rv), 1);
        chk("stream.f_data", 32'(df_rd), n - 1);
        chk("stream.s_data", 32'(ds_rd), n - 1);
      end
    end
    chk("stream.f_maxlvl", fmax, 2);
    pulse_clr();

    // Pointer wrap
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 10; i++) begin
        drive(1, 8'(8'h40 + c * 10 + i), 0);
        chk("wrap.ae_fill", 32'(ds_ae), 32'((i + 1) <= 4));
      end
      for (int i = 0; i < 10; i++) begin
        drive(0, 8'h00, 1);
        chk("wrap.s_data", 32'(ds_rd), 8'h40 + c * 10 + i);
        chk("wrap.ae_drain", 32'(ds_ae), 32'((9 - i) <= 4));
      end
    end
    pulse_clr();

    // Reset mid-stream
    for (int i = 0; i < 7; i++) drive(1, 8'(8'h60 + i), 0);
    wr_en = 0;
    chk("mid.s_lvl_pre", 32'(ds_lvl), 7);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    reset_literals("async");
    step();
    step();
    rst_n = 1;
    drive(1, 8'h11, 0);
    drive(0, 8'h00, 0);
    chk("post.f_rd", 32'(df_rd), 8'h11);
    chk("post.f_empty", 32'(df_empty), 0);
    drive(0, 8'h00, 1);
    chk("post.s_rd", 32'(ds_rd), 8'h11);
    chk("post.s_rv", 32'(ds_rv), 1);
    chk("post.f_empty_pop", 32'(df_empty), 1);
    drive(0, 8'h00, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
